// File: rtl/mesh_router_5p.sv
// Five-port wormhole mesh router: per-input FIFOs with on/off flow control,
// dimension-ordered XY routing and per-output round-robin allocation with packet locking.
module mesh_router_5p #(
  parameter int FLIT_W     = 34,
  parameter int COORD_W    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int OFF_THR    = 6,
  parameter int ON_THR     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COORD_W-1:0]  i_my_x,
  input  logic [COORD_W-1:0]  i_my_y,
  input  logic [5*FLIT_W-1:0] i_flit,
  input  logic [4:0]          i_valid,
  output logic [4:0]          o_on_off,
  output logic [5*FLIT_W-1:0] o_flit,
  output logic [4:0]          o_valid,
  input  logic [4:0]          i_on_off,
  output logic [4:0]          o_overflow
);
  localparam int NP = 5;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic [FLIT_W-1:0] front [NP];
  logic [2:0]        route [NP];
  logic [NP-1:0]     not_empty;
  logic [NP-1:0]     is_head;
  logic [NP-1:0]     pop;

  for (genvar gi = 0; gi < NP; gi++) begin : g_in
    logic [FLIT_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic               on_off_reg;
    logic               overflow_reg;
    logic               full;
    logic               wr_en;
    logic [FLIT_W-1:0]  head_flit;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [2:0]         dir;

    // Full is judged on pre-read occupancy, so write+read of a full FIFO still drops.
    assign full  = (count_reg == CW'(FIFO_DEPTH));
    assign wr_en = i_valid[gi] && !full;

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= i_flit[gi*FLIT_W +: FLIT_W];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        on_off_reg   <= 1'b1;
        overflow_reg <= 1'b0;
      end else begin
        if (wr_en)   wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + AW'(1);
        count_reg <= count_reg + CW'(wr_en) - CW'(pop[gi]);
        if (i_valid[gi] && full) overflow_reg <= 1'b1;
        // Flag follows the occupancy left by the previous edge, i.e. it lags one cycle.
        if (count_reg >= CW'(OFF_THR))     on_off_reg <= 1'b0;
        else if (count_reg <= CW'(ON_THR)) on_off_reg <= 1'b1;
      end
    end

    assign head_flit = mem[rd_ptr_reg];
    assign dest_x    = head_flit[2*COORD_W-1:COORD_W];
    assign dest_y    = head_flit[COORD_W-1:0];

    always_comb begin
      if (dest_x > i_my_x)      dir = 3'd2;
      else if (dest_x < i_my_x) dir = 3'd4;
      else if (dest_y > i_my_y) dir = 3'd1;
      else if (dest_y < i_my_y) dir = 3'd3;
      else                      dir = 3'd0;
    end

    assign front[gi]      = head_flit;
    assign route[gi]      = dir;
    assign not_empty[gi]  = (count_reg != '0);
    assign is_head[gi]    = (head_flit[FLIT_W-1] == head_flit[FLIT_W-2]);
    assign o_on_off[gi]   = on_off_reg;
    assign o_overflow[gi] = overflow_reg;
  end

  function automatic logic [2:0] wrap5(input int v);
    return 3'(v % NP);
  endfunction

  logic [NP-1:0]     lock_reg, lock_next;
  logic [2:0]        owner_reg [NP];
  logic [2:0]        owner_next [NP];
  logic [2:0]        rr_reg [NP];
  logic [2:0]        rr_next [NP];
  logic [2:0]        src [NP];
  logic [NP-1:0]     send;
  logic [FLIT_W-1:0] flit_reg [NP];
  logic [NP-1:0]     valid_reg;

  always_comb begin
    lock_next = lock_reg;
    send      = '0;
    pop       = '0;
    for (int q = 0; q < NP; q++) begin
      owner_next[q] = owner_reg[q];
      rr_next[q]    = rr_reg[q];
      src[q]        = '0;
    end
    for (int q = 0; q < NP; q++) begin
      if (i_on_off[q]) begin
        if (lock_reg[q]) begin
          // Body/tail flits follow the lock; their routing bits are ignored.
          if (not_empty[owner_reg[q]]) begin
            send[q] = 1'b1;
            src[q]  = owner_reg[q];
          end
        end else begin
          for (int k = 0; k < NP; k++) begin
            if (!send[q] && not_empty[wrap5(int'(rr_reg[q]) + k)] &&
                is_head[wrap5(int'(rr_reg[q]) + k)] &&
                route[wrap5(int'(rr_reg[q]) + k)] == 3'(q)) begin
              send[q]       = 1'b1;
              src[q]        = wrap5(int'(rr_reg[q]) + k);
              rr_next[q]    = wrap5(int'(rr_reg[q]) + k + 1);
              owner_next[q] = wrap5(int'(rr_reg[q]) + k);
              lock_next[q]  = (front[src[q]][FLIT_W-1:FLIT_W-2] != T_SINGLE);
            end
          end
        end
        if (send[q]) begin
          pop[src[q]] = 1'b1;
          if (front[src[q]][FLIT_W-1:FLIT_W-2] == T_TAIL) lock_next[q] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_reg  <= '0;
      valid_reg <= '0;
      for (int q = 0; q < NP; q++) begin
        owner_reg[q] <= '0;
        rr_reg[q]    <= '0;
        flit_reg[q]  <= '0;
      end
    end else begin
      lock_reg  <= lock_next;
      valid_reg <= send;
      for (int q = 0; q < NP; q++) begin
        owner_reg[q] <= owner_next[q];
        rr_reg[q]    <= rr_next[q];
        if (send[q]) flit_reg[q] <= front[src[q]];
      end
    end
  end

  for (genvar gi = 0; gi < NP; gi++) begin : g_out
    assign o_flit[gi*FLIT_W +: FLIT_W] = flit_reg[gi];
  end
  assign o_valid = valid_reg;

endmodule

// File: doc/mesh_router_5p.md
Name: mesh_router_5p

Overview:
- Five-port wormhole router for a 2D mesh. Successor to the single-lane input-unit/output-unit router.
- Adds the following:
  - per-port input FIFOs with on/off backpressure and hysteresis;
  - dimension-ordered XY routing;
  - per-output round-robin allocation with packet locking.
- Sits at each mesh node. Port 0 connects to the local network interface; ports 1-4 connect to neighbouring routers.

Parameters:
- FLIT_W, 34: flit width. Bits [FLIT_W-1:FLIT_W-2] are the type (00 head, 01 body, 10 tail, 11 single-flit head+tail). A head carries dest X in [2*COORD_W-1:COORD_W] and dest Y in [COORD_W-1:0].
- COORD_W, 4: coordinate width.
- FIFO_DEPTH, 8: flits per input FIFO; power of two, >=4.
- OFF_THR, 6: occupancy at which o_on_off drops; requires FIFO_DEPTH-OFF_THR >= 2.
- ON_THR, 3: occupancy at or below which o_on_off reasserts; requires ON_THR < OFF_THR.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- i_my_x, in, COORD_W: this node's X coordinate.
- i_my_y, in, COORD_W: this node's Y coordinate.
- i_flit, in, 5*FLIT_W: input flits, port p at [p*FLIT_W +: FLIT_W]. Port order: 0 L, 1 N, 2 E, 3 S, 4 W.
- i_valid, in, 5: flit valid per input port.
- o_on_off, out, 5: per input port; 1 = upstream may send.
- o_flit, out, 5*FLIT_W: output flits, same packing as i_flit.
- o_valid, out, 5: flit valid per output port.
- i_on_off, in, 5: downstream permission per output port.
- o_overflow, out, 5: sticky flag, set when a flit arrives at a full FIFO.

Behaviour:
- Reset values:
  - o_on_off = 5'b11111.
  - o_valid = 0; o_flit = 0; o_overflow = 0.
  - All FIFOs empty, all output locks cleared, all RR pointers = 0.
- Reset mid-packet discards all buffered flits with no tail emitted.
- Input write:
  - i_valid[p] writes FIFO p at the clock edge.
  - If FIFO p is full, the flit is dropped and o_overflow[p] sets; it stays set until reset.
  - Simultaneous write and read of a full FIFO is still an overflow. The write check uses pre-read occupancy.
- On/off (registered, from post-edge occupancy):
  - o_on_off[p] falls to 0 the cycle after occupancy >= OFF_THR.
  - It rises to 1 the cycle after occupancy <= ON_THR.
  - Otherwise it holds.
- XY routing (head at FIFO front, combinational):
  - destX > my_x -> E(2).
  - destX < my_x -> W(4).
  - Else destY > my_y -> N(1).
  - Else destY < my_y -> S(3).
  - Else L(0).
  - No U-turn check.
- Output allocation, per output q:
  - State FREE or LOCKED(owner).
  - FREE: candidates are inputs whose FIFO-front flit is a head routed to q.
    - Round-robin grant starting at rr_ptr[q].
    - On grant, rr_ptr[q] = winner+1 mod 5.
    - Output goes LOCKED(winner) unless the flit is type 11, in which case it stays FREE.
  - LOCKED(i): only input i may send to q. Body/tail flits follow the owner's lock regardless of routing bits.
  - A tail (10) sent returns q to FREE in the same edge.
  - A grant requires i_on_off[q]=1 in that cycle.
- Transfer:
  - A flit moves FIFO -> output register when its input is granted/owner, the FIFO is non-empty, and i_on_off[q]=1.
  - Output register is loaded at the edge.
  - o_valid[q]=1 for exactly one cycle per flit; o_flit holds its last value when o_valid=0.
  - An input owns at most one output; one flit per input per cycle.
- Latency: a flit sampled at cycle 0 with no contention appears on o_flit/o_valid in cycle 2.
- Throughput: 1 flit/cycle/output.
- Downstream stall: i_on_off[q]=0 freezes the lock; the packet resumes when i_on_off[q] returns to 1.
- Non-head flit at the front of an unlocked input: it waits and is never routed. This is a protocol violation; the bench asserts it never occurs.

Test Plan:
- my=(1,1); 3-flit packet dest(3,1) into W(4) at cycle 0 -> head on E(2) at cycle 2, body 3, tail 4; E returns to FREE after tail.
- Single-flit packets dest(1,1) into N and S in the same cycle, rr_ptr[0]=0 -> N on L at cycle 2, S at cycle 3, rr_ptr[0]=4.
- 4-flit packet from L to E; a competing head from N to E arrives after the L head is granted -> N head waits; N packet starts the cycle after the L tail is sent; no interleaving.
- i_on_off[E]=0 for 10 cycles while W streams 8 flits -> o_on_off[4]=0 the cycle after occupancy hits 6; reasserts after drain to 3; zero flits lost; o_overflow=0.
- Ignore o_on_off and write 9 flits back-to-back into a stalled port -> 9th flit dropped, o_overflow[p]=1 sticky.
- Assert reset mid-packet -> next cycle all o_valid=0, o_on_off=11111, FIFOs empty; a new packet routes normally.
